// File: rtl/aes256_inv_key_schedule_if.sv
// ---------------------------------------------------------------------------
// aes256_inv_key_schedule_if
//
// Bundles the key-load and round-key handshakes of aes256_inv_key_schedule.
//
//   key_i        256  {w52..w59} of the expanded key, w52 in [255:224]
//   v_i          1    key_i valid
//   ready_o      1    block idle, will accept a key
//   round_key_o  128  round key for round round_o
//   round_o      4    round index, 14 down to 0
//   v_o          1    round_key_o / round_o valid
//   yumi_i       1    consumer takes the current round key
//
// Handshake semantics: a key transfer happens on a rising clock edge where
// v_i=1 and ready_o=1; v_i is ignored while ready_o=0. A round-key transfer
// happens on a rising edge where v_o=1 and yumi_i=1; yumi_i may only be
// raised while v_o=1 (the block ignores it otherwise). While yumi_i=0 the
// offered round key and round index stay stable.
//
// Modports: slave = the key-schedule block, master = its environment.
// ---------------------------------------------------------------------------
interface aes256_inv_key_schedule_if;
    logic [255:0] key_i;
    logic         v_i;
    logic         ready_o;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         v_o;
    logic         yumi_i;

    modport master (
        output key_i, v_i, yumi_i,
        input  ready_o, round_key_o, round_o, v_o
    );

    modport slave (
        input  key_i, v_i, yumi_i,
        output ready_o, round_key_o, round_o, v_o
    );
endinterface

// File: rtl/aes256_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes256_inv_key_schedule
//
// Reverse AES-256 key schedule. Accepts the last 256 bits of the expanded
// key (w52..w59) and emits round keys 14 down to 0, one per yumi_i, by
// inverting w[i] = w[i-8] ^ T(w[i-1]).
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous reset, active-high
//   ks_if        aes256_inv_key_schedule_if.slave (key load / round-key out)
//   state_dbg_o  FSM state: 0 = IDLE, 1 = RUN
//
// Optional feature macro: AES_INV_KS_ZEROIZE_EN
//   Defined   : consuming round 0 clears hi_q, lo_q and round_q.
//   Undefined : registers keep the round 0 key after the schedule ends.
//
// Also contains the helper ROMs rom_sbox (AES S-box) and rom_rc (Rcon).
// ---------------------------------------------------------------------------

// AES forward S-box, one byte lookup.
module rom_sbox (
    input  logic [7:0] rom_addr,
    output logic [7:0] data_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SBOX[rom_addr];
endmodule

// Round constant ROM: address k holds Rcon[k+1].
module rom_rc #(
    parameter int width_p      = 8,
    parameter int addr_width_p = 4
) (
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o
);
    always_comb begin
        data_o = '0;
        case (int'(addr_i))
            0: data_o = width_p'(8'h01);
            1: data_o = width_p'(8'h02);
            2: data_o = width_p'(8'h04);
            3: data_o = width_p'(8'h08);
            4: data_o = width_p'(8'h10);
            5: data_o = width_p'(8'h20);
            6: data_o = width_p'(8'h40);
            7: data_o = width_p'(8'h80);
            8: data_o = width_p'(8'h1b);
            9: data_o = width_p'(8'h36);
            default: data_o = '0;
        endcase
    end
endmodule

module aes256_inv_key_schedule (
    input  logic                             clk_i,
    input  logic                             reset_i,
    aes256_inv_key_schedule_if.slave         ks_if,
    output logic                             state_dbg_o
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] hi_q, hi_d;      // R(cur), drives round_key_o
    logic [127:0] lo_q, lo_d;      // R(cur-1)
    logic [3:0]   round_q, round_d;

    // ---------------------------------------------------------------------
    // Next-key datapath: N = R(cur-2) from R(cur) and the last word of
    // R(cur-1). Meaningless when cur < 2; that value is never shown.
    // ---------------------------------------------------------------------
    logic [31:0]  a0, a1, a2, a3, b3;
    logic [3:0]   r_m2;
    logic         r_even;
    logic [31:0]  sbox_in;
    logic [31:0]  sub_word;
    logic [3:0]   rc_addr;
    logic [7:0]   rcon;
    logic [31:0]  word0;
    logic [127:0] next_key;

    assign a0 = hi_q[127:96];
    assign a1 = hi_q[95:64];
    assign a2 = hi_q[63:32];
    assign a3 = hi_q[31:0];
    assign b3 = lo_q[31:0];

    // r = cur-2 has the same parity as cur.
    assign r_m2    = round_q - 4'd2;
    assign r_even  = ~round_q[0];
    assign sbox_in = r_even ? {b3[23:0], b3[31:24]} : b3;
    assign rc_addr = {1'b0, r_m2[3:1]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        rom_sbox u_sbox (
            .rom_addr (sbox_in[8*gi +: 8]),
            .data_o   (sub_word[8*gi +: 8])
        );
    end

    rom_rc #(
        .width_p      (8),
        .addr_width_p (4)
    ) u_rc (
        .addr_i (rc_addr),
        .data_o (rcon)
    );

    assign word0    = a0 ^ sub_word ^ (r_even ? {rcon, 24'h0} : 32'h0);
    assign next_key = {word0, a1 ^ a0, a2 ^ a1, a3 ^ a2};

    // ---------------------------------------------------------------------
    // FSM / register next-state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (ks_if.v_i) begin
                    hi_d    = ks_if.key_i[127:0];
                    lo_d    = ks_if.key_i[255:128];
                    round_d = 4'd14;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ks_if.yumi_i) begin
                    if (round_q != 4'd0) begin
                        hi_d    = lo_q;
                        lo_d    = next_key;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
`ifdef AES_INV_KS_ZEROIZE_EN
                        hi_d    = '0;
                        lo_d    = '0;
                        round_d = '0;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            round_q <= round_d;
        end
    end

    assign ks_if.ready_o     = (state_q == ST_IDLE);
    assign ks_if.v_o         = (state_q == ST_RUN);
    assign ks_if.round_key_o = hi_q;
    assign ks_if.round_o     = round_q;
    assign state_dbg_o       = (state_q == ST_RUN);
endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes256_inv_key_schedule
//
// Bench for aes256_inv_key_schedule. Expected round keys come from a forward
// AES-256 key expansion whose S-box is derived from GF(2^8) inversion plus
// the affine map, and whose Rcon is generated by repeated xtime.
// ---------------------------------------------------------------------------
module tb_aes256_inv_key_schedule;

`ifdef AES_INV_KS_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic state_dbg;

    always #5 clk = ~clk;

    aes256_inv_key_schedule_if ks_if ();

    aes256_inv_key_schedule dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .ks_if       (ks_if.slave),
        .state_dbg_o (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];
    logic [3:0]   exp_r_q[$];

    logic [7:0]  sb[256];
    logic [31:0] w_m[60];

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } vec_t;
    vec_t fips_tab[3];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] ck);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w_m[i] = ck[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w_m[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w_m[i] = w_m[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        return {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
    endfunction

    function automatic logic [255:0] model_load();
        return {w_m[52], w_m[53], w_m[54], w_m[55], w_m[56], w_m[57], w_m[58], w_m[59]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ks_if.ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("wait_ready", 128'(ks_if.ready_o), 128'd1);
    endtask

    // Loads the model's w52..w59; returns at t+1.
    task automatic load_model_key();
        wait_ready();
        ks_if.key_i = model_load();
        ks_if.v_i   = 1'b1;
        tick();
        ks_if.v_i   = 1'b0;
        ks_if.key_i = '0;
    endtask

    task automatic check_idle_after(input string tag);
        check({tag, "_ready"}, 128'(ks_if.ready_o), 128'd1);
        check({tag, "_v_o"}, 128'(ks_if.v_o), 128'd0);
        check({tag, "_round"}, 128'(ks_if.round_o), 128'd0);
        check({tag, "_key"}, ks_if.round_key_o, ZEROIZE ? 128'h0 : model_rk(0));
    endtask

    // Full schedule with random yumi_i; optional random v_i pulses during RUN.
    task automatic run_sched(input logic [255:0] ck, input int yumi_pct, input bit pulse_vi);
        int  cycles;
        bit  y;
        expand(ck);
        for (int r = 14; r >= 0; r--) begin
            exp_q.push_back(model_rk(r));
            exp_r_q.push_back(4'(r));
        end
        load_model_key();
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 400) begin
            check("run_v_o", 128'(ks_if.v_o), 128'd1);
            check("run_ready_o", 128'(ks_if.ready_o), 128'd0);
            check("run_round", 128'(ks_if.round_o), 128'(exp_r_q[0]));
            check("run_key", ks_if.round_key_o, exp_q[0]);
            y = ($urandom_range(99) < yumi_pct);
            ks_if.yumi_i = y;
            if (pulse_vi) begin
                ks_if.v_i   = 1'($urandom_range(1));
                ks_if.key_i = rand_key();
            end
            tick();
            if (y) begin
                void'(exp_q.pop_front());
                void'(exp_r_q.pop_front());
            end
            cycles++;
        end
        ks_if.yumi_i = 1'b0;
        ks_if.v_i    = 1'b0;
        ks_if.key_i  = '0;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got %0d keys left expected 0", exp_q.size());
            exp_q.delete();
            exp_r_q.delete();
        end
        check_idle_after("run_end");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] got[15];
        int n;

        ks_if.key_i  = '0;
        ks_if.v_i    = 1'b0;
        ks_if.yumi_i = 1'b0;

        fips_tab[0] = '{rnd: 4'd14, key: 128'h24fc79ccbf0979e9371ac23c6d68de36};
        fips_tab[1] = '{rnd: 4'd1,  key: 128'h101112131415161718191a1b1c1d1e1f};
        fips_tab[2] = '{rnd: 4'd0,  key: 128'h000102030405060708090a0b0c0d0e0f};

        build_sbox();
        do_reset();

        // Reset state
        check("rst_ready", 128'(ks_if.ready_o), 128'd1);
        check("rst_v_o", 128'(ks_if.v_o), 128'd0);
        check("rst_key", ks_if.round_key_o, 128'h0);
        check("rst_round", 128'(ks_if.round_o), 128'd0);

        // yumi_i while idle is ignored
        ks_if.yumi_i = 1'b1;
        tick();
        ks_if.yumi_i = 1'b0;
        check("idle_yumi_ready", 128'(ks_if.ready_o), 128'd1);
        check("idle_yumi_v_o", 128'(ks_if.v_o), 128'd0);
        check("idle_yumi_round", 128'(ks_if.round_o), 128'd0);

        // FIPS-197 key, continuous yumi_i: keys on t+1..t+15, ready at t+16
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        load_model_key();
        ks_if.yumi_i = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            got[15 - c] = ks_if.round_key_o;
            check("fips_v_o", 128'(ks_if.v_o), 128'd1);
            check("fips_round", 128'(ks_if.round_o), 128'(15 - c));
            check("fips_model_key", ks_if.round_key_o, model_rk(15 - c));
            tick();
        end
        ks_if.yumi_i = 1'b0;
        check("fips_t16_ready", 128'(ks_if.ready_o), 128'd1);
        check("fips_t16_v_o", 128'(ks_if.v_o), 128'd0);
        check("fips_t16_key", ks_if.round_key_o,
              ZEROIZE ? 128'h0 : 128'h000102030405060708090a0b0c0d0e0f);
        for (int i = 0; i < 3; i++)
            check($sformatf("fips_tab_r%0d", fips_tab[i].rnd), got[fips_tab[i].rnd], fips_tab[i].key);

        // v_i pulsed during RUN is ignored
        for (int k = 0; k < 5; k++) run_sched(rand_key(), 60, 1'b1);

        // reset_i asserted at round 7
        expand(rand_key());
        load_model_key();
        ks_if.yumi_i = 1'b1;
        n = 0;
        while (ks_if.round_o !== 4'd7 && n < 20) begin
            tick();
            n++;
        end
        check("rst7_reached", 128'(ks_if.round_o), 128'd7);
        check("rst7_key", ks_if.round_key_o, model_rk(7));
        ks_if.yumi_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("rst7_ready", 128'(ks_if.ready_o), 128'd1);
        check("rst7_v_o", 128'(ks_if.v_o), 128'd0);
        check("rst7_key0", ks_if.round_key_o, 128'h0);
        check("rst7_round0", 128'(ks_if.round_o), 128'd0);
        run_sched(rand_key(), 70, 1'b0);

        // 100 random keys with random back-pressure
        for (int k = 0; k < 100; k++) run_sched(rand_key(), $urandom_range(30, 90), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #5ms;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes256_inv_key_schedule.md
# aes256_inv_key_schedule

Reverse AES-256 key schedule for the decryption datapath. It takes the last 256 bits of the expanded key (words w52..w59) and produces round keys 14 down to 0, one per accepted output cycle. Each step inverts the forward recurrence w[i] = w[i-8] ^ T(w[i-1]). It sits between key storage and the inverse-cipher round engine, which consumes keys in reverse round order.

## Interface
- No parameters. The block is fixed to AES-256, with 15 round keys of 128 bits each.
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- key_i  in  256  {w52,w53,...,w59}, with w52 at [255:224]; [255:128] is round key 13 and [127:0] is round key 14
- v_i  in  1  key_i valid
- ready_o  out  1  block is idle and will accept a key
- round_key_o  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]} for round r = round_o
- round_o  out  4  round index of round_key_o, 14..0
- v_o  out  1  round_key_o / round_o valid
- yumi_i  in  1  consumer takes the current key; legal only while v_o=1

## Operation
- States: IDLE and RUN.
- Registers:
  - hi_q[127:0] holds R(cur) and drives round_key_o.
  - lo_q[127:0] holds R(cur-1).
  - round_q[3:0] holds cur and drives round_o.
- IDLE behaviour:
  - ready_o=1, v_o=0.
  - On v_i=1: hi_q<=key_i[127:0], lo_q<=key_i[255:128], round_q<=14, then go to RUN.
- RUN behaviour:
  - ready_o=0, v_o=1. v_i is ignored.
  - On yumi_i with round_q>0: hi_q<=lo_q, lo_q<=N, round_q<=round_q-1.
  - On yumi_i with round_q==0: return to IDLE.
- Computing N = R(cur-2), with a0..a3 = hi_q words (MSB first), b3 = last word of lo_q, and r = cur-2:
  - N word1 = a1^a0, word2 = a2^a1, word3 = a3^a2.
  - N word0 for r even: a0 ^ SubWord(RotWord(b3)) ^ {Rcon[r/2+1],24'h0}.
  - N word0 for r odd: a0 ^ SubWord(b3).
  - RotWord is {b3[23:0],b3[31:24]}.
- S-box and Rcon sources:
  - Four rom_sbox instances (rom_addr, data_o), one per byte, shared by both word0 cases.
  - Rcon from rom_rc (width_p=8, addr_width_p=4) with addr_i = r/2. Address 0 gives 8'h01; address 6 gives 8'h40.
- At cur==1, N is not meaningful. lo_q may take any value and is never output.
- A yumi_i asserted while v_o=0 is a protocol violation. The block ignores it.

## Timing
- Reset values: state IDLE, hi_q=0, lo_q=0, round_q=0, so v_o=0, ready_o=1, round_key_o=0, round_o=0.
- Load: a key accepted in cycle t gives v_o=1 with round_o=14 at t+1.
- Throughput: one round key per cycle under continuous yumi_i. The 15 keys occupy cycles t+1..t+15, and ready_o=1 again at t+16.
- Minimum key-to-key spacing is 16 cycles.
- Back-pressure: with yumi_i=0, round_key_o and round_o hold stable and v_o stays 1.
- The next-key logic is combinational from hi_q/lo_q, with a critical path of S-box plus three XORs. All outputs come directly from registers or state.
- reset_i during RUN: the next cycle shows reset values. Any partially delivered schedule is discarded.
- ready_o and v_o are never high in the same cycle.

## Configuration
- AES_INV_KS_ZEROIZE_EN:
  - Defined: the RUN-to-IDLE transition (round 0 consumed) also clears hi_q, lo_q and round_q to 0. Key material never lingers, and round_key_o reads 0 in IDLE.
  - Undefined: registers keep their last values in IDLE. round_key_o then shows the round 0 key (with v_o=0).

## Test plan
- Reset, then idle: ready_o=1, v_o=0, round_key_o=0, round_o=0.
- FIPS-197 AES-256 key 000102..1f:
  - Stimulus: load w52..w59 from the bench's forward expansion, yumi_i held high.
  - round_o 14 gives 24fc79ccbf0979e9371ac23c6d68de36.
  - round_o 1 gives 101112131415161718191a1b1c1d1e1f.
  - round_o 0 gives 000102030405060708090a0b0c0d0e0f, on consecutive cycles t+1..t+15.
  - ready_o=1 at t+16.
- Random yumi_i back-pressure on 100 random keys: every round key matches the forward-expansion model, and the output holds while yumi_i=0.
- v_i pulsed during RUN: ignored, and the schedule completes unchanged.
- reset_i asserted at round_o=7: reset values next cycle; a new key then starts cleanly at round 14.
- Zeroize check:
  - With AES_INV_KS_ZEROIZE_EN: round_key_o=0 the cycle after round 0 is consumed.
  - Without it: round_key_o holds 000102030405060708090a0b0c0d0e0f with v_o=0.
